cluster_unpacker: RTL and testbench
===================================

// Module: cluster_unpacker
// PURPOSE
//   Inverse of the cluster packer: expands the 8 cluster words of one bunch crossing
//   (cnt[13:11], adr[10:0]) back into a 1536-bit S-bit hitmap (24 VFAT3 x 64 strips).
//   Sits on the receive side of the trigger link, and in the verification bench as the
//   reference decoder for the packer. Runs on the clock4x domain and expands 2 clusters per beat.
// PARAMETERS
//   NUM_CLUSTERS  8     cluster words per frame; must be even
//   NUM_SBITS     1536  hitmap width; addresses >= NUM_SBITS are "no cluster"
//   ADR_BITS      11    address field width
//   CNT_BITS      3     size field width; cluster size = cnt+1 strips
// PORTS
//   clock4x         in   1     160 MHz clock; the only clock
//   global_reset    in   1     synchronous, active-high reset
//   clusters_valid  in   1     1-cycle strobe: cluster0..7 hold a new frame
//   cluster0..7     in   14    {cnt[2:0], adr[10:0]}
//   busy            out  1     expansion in progress; a strobe now is dropped unless on the final beat
//   sbits           out  1536  decoded hitmap, held until the next publish
//   sbits_valid     out  1     1-cycle pulse when sbits updates
//   n_clusters      out  4     count of valid clusters in the published frame (0..8)
//   frame_dropped   out  1     1-cycle pulse when a strobe is lost while busy
// BEHAVIOUR
//   - Reset (sync): state=IDLE; sbits=0, sbits_valid=0, n_clusters=0, busy=0,
//     frame_dropped=0; accumulator and capture regs cleared. Reset mid-expansion aborts
//     the frame; nothing is published.
//   - FSM states: IDLE, EXPAND (beat counter 0..NUM_CLUSTERS/2-1).
//     IDLE + clusters_valid -> capture all 8 words, clear accumulator, go to EXPAND beat 0.
//     EXPAND beat k: OR in the strips of clusters 2k and 2k+1; count the valid ones.
//     Final beat -> go to IDLE, or on a coincident strobe capture the new frame and go to beat 0.
//   - Publish: the cycle after the final beat, sbits <= accumulator | last-beat strips,
//     n_clusters <= total, sbits_valid=1.
//     Latency: strobe at cycle T -> sbits_valid at T+5. Sustained rate: one frame per 4 cycles.
//   - busy=1 in EXPAND except on the final beat. A strobe on a non-final beat is ignored
//     and raises frame_dropped for 1 cycle. The frame in progress is not disturbed.
//   - Cluster valid iff adr < NUM_SBITS (0x7FF / 0x600-0x7FF = empty).
//     Strips set: adr .. adr+cnt, computed at 12 bits. Bits >= NUM_SBITS are clipped;
//     there is no wrap to bit 0.
//   - Overlapping clusters OR together. Duplicates are not an error.
//   - Input words are used only as captured at the strobe; later input changes are ignored.
// CONFIGURATION
//   CLUSTER_UNPACKER_OVERLAP_CHECK_EN
//     defined: adds output overlap_err (1 bit). It pulses with sbits_valid when any strip
//       was set by more than one cluster in the frame, including the 2 clusters of the same
//       beat and clusters of earlier beats. Reset value 0.
//     undefined: port and logic absent; overlaps silently OR.
// TESTING
//   1 reset held 3 cycles, then released -> all outputs 0, busy=0. A strobe during reset is
//     ignored.
//   2 cluster0={cnt=1,adr=2}, others 0x7FF, strobe at T -> at T+5: sbits[3:2]=2'b11 and all
//     other bits 0; n_clusters=1; sbits_valid high for exactly 1 cycle.
//   3 8 clusters {cnt=1, adr=192*i} for i=0..7 -> sbits has bits 192i, 192i+1 set, 16 bits
//     total; n_clusters=8.
//   4 cluster0={cnt=7,adr=1532} -> bits 1532..1535 set; no low bits set. adr=1536 -> empty,
//     n_clusters=0.
//   5 strobes every 4 cycles for 10 frames -> 10 sbits_valid pulses, one every 4 cycles,
//     no frame_dropped. A strobe 2 cycles after another -> frame_dropped pulse and only the
//     first frame is published.
//   6 OVERLAP_CHECK_EN: cluster0={3,10}, cluster5={0,12} -> overlap_err=1 with sbits_valid.
//     Disjoint clusters -> overlap_err=0.
//   Plus a randomized loopback: random 1536-bit frames through cluster_packer into this
//     block -> decoded map equals the input whenever the frame holds <= 8 clusters of size
//     <= 8.

Source files
------------

// File: rtl/cluster_unpacker.sv
// cluster_unpacker: expands one bunch crossing of cluster words into the 1536-bit S-bit
// hitmap, two clusters per clock4x beat. Optional overlap flag: CLUSTER_UNPACKER_OVERLAP_CHECK_EN.
module cluster_unpacker #(
  parameter int NUM_CLUSTERS = 8,
  parameter int NUM_SBITS    = 1536,
  parameter int ADR_BITS     = 11,
  parameter int CNT_BITS     = 3
) (
  input  logic                         clock4x,
  input  logic                         global_reset,
  input  logic                         clusters_valid,
  input  logic [CNT_BITS+ADR_BITS-1:0] cluster0,
  input  logic [CNT_BITS+ADR_BITS-1:0] cluster1,
  input  logic [CNT_BITS+ADR_BITS-1:0] cluster2,
  input  logic [CNT_BITS+ADR_BITS-1:0] cluster3,
  input  logic [CNT_BITS+ADR_BITS-1:0] cluster4,
  input  logic [CNT_BITS+ADR_BITS-1:0] cluster5,
  input  logic [CNT_BITS+ADR_BITS-1:0] cluster6,
  input  logic [CNT_BITS+ADR_BITS-1:0] cluster7,
  output logic                         busy,
  output logic [NUM_SBITS-1:0]         sbits,
  output logic                         sbits_valid,
  output logic [3:0]                   n_clusters,
  output logic                         frame_dropped,
  output logic                         dbg_state
`ifdef CLUSTER_UNPACKER_OVERLAP_CHECK_EN
  ,
  output logic                         overlap_err
`endif
);

  localparam int WORD_W    = CNT_BITS + ADR_BITS;
  localparam int NUM_BEATS = NUM_CLUSTERS / 2;
  localparam int BEAT_W    = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam int MAX_SIZE  = 1 << CNT_BITS;
  localparam logic [ADR_BITS:0]   ADR_LIMIT = (ADR_BITS + 1)'(NUM_SBITS);
  localparam logic [BEAT_W-1:0]   LAST_BEAT = BEAT_W'(NUM_BEATS - 1);
  localparam logic [CNT_BITS-1:0] CNT_MAX   = CNT_BITS'(MAX_SIZE - 1);

  // Handshake: clusters_valid is a single-cycle strobe with no backpressure. It is accepted
  // in IDLE or on the final beat (busy=0); any other strobe is dropped and reported.
  typedef enum logic {IDLE = 1'b0, EXPAND = 1'b1} state_t;

  state_t              state, state_nx;
  logic [BEAT_W-1:0]   beat, beat_nx;
  logic [WORD_W-1:0]   in_word [8];
  logic [WORD_W-1:0]   cap [8];
  logic [NUM_SBITS-1:0] acc;
  logic [3:0]          cnt_acc;
  logic [NUM_SBITS-1:0] mask_a, mask_b, beat_mask;
  logic                valid_a, valid_b;
  logic [1:0]          beat_cnt;
  logic                last_beat, capture, publish, drop;

  assign in_word[0] = cluster0;
  assign in_word[1] = cluster1;
  assign in_word[2] = cluster2;
  assign in_word[3] = cluster3;
  assign in_word[4] = cluster4;
  assign in_word[5] = cluster5;
  assign in_word[6] = cluster6;
  assign in_word[7] = cluster7;
  assign dbg_state  = state;

  function automatic logic word_valid(input logic [WORD_W-1:0] w);
    return {1'b0, w[ADR_BITS-1:0]} < ADR_LIMIT;
  endfunction

  // Run of cnt+1 ones shifted up to adr; anything past the top of the map falls off the end.
  function automatic logic [NUM_SBITS-1:0] strip_mask(input logic [WORD_W-1:0] w);
    logic [CNT_BITS-1:0] cnt;
    logic [MAX_SIZE-1:0] run;
    cnt = w[WORD_W-1:ADR_BITS];
    run = {MAX_SIZE{1'b1}} >> (CNT_MAX - cnt);
    if (word_valid(w))
      return {{(NUM_SBITS - MAX_SIZE){1'b0}}, run} << w[ADR_BITS-1:0];
    return '0;
  endfunction

  always_comb begin
    mask_a    = strip_mask(cap[{beat, 1'b0}]);
    mask_b    = strip_mask(cap[{beat, 1'b1}]);
    valid_a   = word_valid(cap[{beat, 1'b0}]);
    valid_b   = word_valid(cap[{beat, 1'b1}]);
    beat_mask = mask_a | mask_b;
    beat_cnt  = {1'b0, valid_a} + {1'b0, valid_b};
  end

  always_comb begin
    state_nx  = state;
    beat_nx   = beat;
    capture   = 1'b0;
    publish   = 1'b0;
    drop      = 1'b0;
    last_beat = (beat == LAST_BEAT);
    busy      = (state == EXPAND) && !last_beat;
    case (state)
      IDLE: begin
        if (clusters_valid) begin
          capture  = 1'b1;
          state_nx = EXPAND;
          beat_nx  = '0;
        end
      end
      EXPAND: begin
        if (last_beat) begin
          publish = 1'b1;
          beat_nx = '0;
          if (clusters_valid) capture = 1'b1;
          else state_nx = IDLE;
        end else begin
          beat_nx = beat + 1'b1;
          drop    = clusters_valid;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

`ifdef CLUSTER_UNPACKER_OVERLAP_CHECK_EN
  logic ovl_acc, beat_ovl;
  // A strip collides if the two clusters of this beat share it, or an earlier beat set it.
  assign beat_ovl = (|(mask_a & mask_b)) | (|(beat_mask & acc));

  always_ff @(posedge clock4x) begin
    if (global_reset) begin
      ovl_acc     <= 1'b0;
      overlap_err <= 1'b0;
    end else begin
      overlap_err <= publish && (ovl_acc || beat_ovl);
      if (state == EXPAND) ovl_acc <= ovl_acc | beat_ovl;
      if (capture) ovl_acc <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clock4x) begin
    if (global_reset) begin
      state         <= IDLE;
      beat          <= '0;
      acc           <= '0;
      cnt_acc       <= '0;
      sbits         <= '0;
      sbits_valid   <= 1'b0;
      n_clusters    <= '0;
      frame_dropped <= 1'b0;
      for (int i = 0; i < 8; i++) cap[i] <= '0;
    end else begin
      state         <= state_nx;
      beat          <= beat_nx;
      sbits_valid   <= publish;
      frame_dropped <= drop;
      if (state == EXPAND) begin
        acc     <= acc | beat_mask;
        cnt_acc <= cnt_acc + {2'b00, beat_cnt};
      end
      if (publish) begin
        sbits      <= acc | beat_mask;
        n_clusters <= cnt_acc + {2'b00, beat_cnt};
      end
      // Capture last so a back-to-back frame starts from a clean accumulator.
      if (capture) begin
        for (int i = 0; i < 8; i++) cap[i] <= in_word[i];
        acc     <= '0;
        cnt_acc <= '0;
      end
    end
  end

endmodule

// File: tb/tb_cluster_unpacker.sv
// tb_cluster_unpacker: randomized bench for cluster_unpacker against a bit-level hitmap model.
// Build with CLUSTER_UNPACKER_OVERLAP_CHECK_EN defined to also exercise overlap_err.
module tb_cluster_unpacker;

  typedef logic [7:0][13:0] frame_t;
  localparam logic [13:0] EMPTY = 14'h07FF;

  logic          clk = 1'b0;
  logic          global_reset = 1'b1;
  logic          clusters_valid = 1'b0;
  logic [13:0]   cl [8];
  logic          busy;
  logic [1535:0] sbits;
  logic          sbits_valid;
  logic [3:0]    n_clusters;
  logic          frame_dropped;
  logic          dbg_state;
`ifdef CLUSTER_UNPACKER_OVERLAP_CHECK_EN
  logic          overlap_err;
`endif

  int checks = 0;
  int errors = 0;
  logic [1535:0] exp_q [$];
  logic [3:0]    n_q [$];
  logic          obs_ovl = 1'b0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  cluster_unpacker dut (
    .clock4x(clk), .global_reset(global_reset), .clusters_valid(clusters_valid),
    .cluster0(cl[0]), .cluster1(cl[1]), .cluster2(cl[2]), .cluster3(cl[3]),
    .cluster4(cl[4]), .cluster5(cl[5]), .cluster6(cl[6]), .cluster7(cl[7]),
    .busy(busy), .sbits(sbits), .sbits_valid(sbits_valid), .n_clusters(n_clusters),
    .frame_dropped(frame_dropped), .dbg_state(dbg_state)
`ifdef CLUSTER_UNPACKER_OVERLAP_CHECK_EN
    , .overlap_err(overlap_err)
`endif
  );

  // ---------------- reference model ----------------
  function automatic logic [1535:0] ref_map(input frame_t f);
    logic [1535:0] m = '0;
    for (int i = 0; i < 8; i++) begin
      int a = int'(f[i][10:0]);
      int c = int'(f[i][13:11]);
      if (a < 1536)
        for (int j = 0; j <= c; j++)
          if (a + j < 1536) m[a + j] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic [3:0] ref_count(input frame_t f);
    int n = 0;
    for (int i = 0; i < 8; i++) if (int'(f[i][10:0]) < 1536) n++;
    return 4'(n);
  endfunction

  // Packer stand-in: runs of set bits split into clusters of at most 8 strips.
  function automatic int pack_map(input logic [1535:0] m, output frame_t f);
    int n = 0;
    int i = 0;
    for (int k = 0; k < 8; k++) f[k] = EMPTY;
    while (i < 1536) begin
      if (m[i]) begin
        int len = 0;
        while (i + len < 1536 && m[i + len] && len < 8) len++;
        if (n < 8) f[n] = {3'(len - 1), 11'(i)};
        n++;
        i += len;
      end else begin
        i++;
      end
    end
    return n;
  endfunction

  function automatic frame_t rand_frame();
    frame_t f;
    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(0, 3) == 0) f[i] = {3'($urandom_range(0, 7)), 11'($urandom_range(1536, 2047))};
      else f[i] = {3'($urandom_range(0, 7)), 11'($urandom_range(0, 1535))};
    end
    return f;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_words(input frame_t f);
    for (int i = 0; i < 8; i++) cl[i] = f[i];
  endtask

  task automatic set_junk();
    for (int i = 0; i < 8; i++) cl[i] = 14'($urandom);
  endtask

  // Strobes one frame, then watches 10 cycles; lat is the cycle of the first sbits_valid.
  task automatic run_frame(input frame_t f, output logic [1535:0] map, output logic [3:0] n,
                           output int lat, output int pulses, output int drops);
    lat = -1; pulses = 0; drops = 0; map = '0; n = '0;
    @(negedge clk);
    set_words(f);
    clusters_valid = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) begin
        clusters_valid = 1'b0;
        set_junk();
      end
      if (sbits_valid) begin
        pulses++;
        if (lat < 0) begin
          lat = k; map = sbits; n = n_clusters;
`ifdef CLUSTER_UNPACKER_OVERLAP_CHECK_EN
          obs_ovl = overlap_err;
`endif
        end
      end
      if (frame_dropped) drops++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int pulses = 0;
    global_reset = 1'b1;
    @(negedge clk);
    set_words({8{14'h0802}});
    clusters_valid = 1'b1;
    @(negedge clk);
    clusters_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    global_reset = 1'b0;
    checks++; if (sbits !== '0) begin errors++; $display("FAIL reset_sbits: got popcount %0d want 0", $countones(sbits)); end
    checks++; if (sbits_valid !== 1'b0) begin errors++; $display("FAIL reset_sbits_valid: got %b want 0", sbits_valid); end
    checks++; if (n_clusters !== 4'd0) begin errors++; $display("FAIL reset_n_clusters: got %0d want 0", n_clusters); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (frame_dropped !== 1'b0) begin errors++; $display("FAIL reset_frame_dropped: got %b want 0", frame_dropped); end
    repeat (8) begin
      @(negedge clk);
      if (sbits_valid) pulses++;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL reset_strobe_ignored: got %0d publishes want 0", pulses); end
  endtask

  task automatic test_reset_abort();
    int pulses = 0;
    frame_t f = rand_frame();
    @(negedge clk);
    set_words(f);
    clusters_valid = 1'b1;
    @(negedge clk);
    clusters_valid = 1'b0;
    @(negedge clk);
    global_reset = 1'b1;
    @(negedge clk);
    global_reset = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (sbits_valid) pulses++;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL abort_publish: got %0d publishes want 0", pulses); end
    checks++; if (sbits !== '0) begin errors++; $display("FAIL abort_sbits: got popcount %0d want 0", $countones(sbits)); end
  endtask

  task automatic test_single();
    frame_t f = {8{EMPTY}};
    logic [1535:0] m; logic [3:0] n; int lat, pulses, drops;
    f[0] = {3'd1, 11'd2};
    run_frame(f, m, n, lat, pulses, drops);
    checks++; if (lat != 5) begin errors++; $display("FAIL single_latency: got %0d want 5", lat); end
    checks++; if (pulses != 1) begin errors++; $display("FAIL single_pulse_width: got %0d want 1", pulses); end
    checks++; if (m !== ref_map(f)) begin errors++; $display("FAIL single_map: got low bits %h want %h", m[15:0], ref_map(f)[15:0]); end
    checks++; if ($countones(m) != 2 || m[3:2] !== 2'b11) begin errors++; $display("FAIL single_bits: got popcount %0d bits3_2 %b want 2 and 11", $countones(m), m[3:2]); end
    checks++; if (n !== 4'd1) begin errors++; $display("FAIL single_count: got %0d want 1", n); end
  endtask

  task automatic test_spread();
    frame_t f;
    logic [1535:0] m; logic [3:0] n; int lat, pulses, drops;
    for (int i = 0; i < 8; i++) f[i] = {3'd1, 11'(192 * i)};
    run_frame(f, m, n, lat, pulses, drops);
    checks++; if (m !== ref_map(f)) begin errors++; $display("FAIL spread_map: got popcount %0d want %0d", $countones(m), $countones(ref_map(f))); end
    checks++; if ($countones(m) != 16) begin errors++; $display("FAIL spread_popcount: got %0d want 16", $countones(m)); end
    checks++; if (n !== 4'd8) begin errors++; $display("FAIL spread_count: got %0d want 8", n); end
  endtask

  task automatic test_edges();
    frame_t f = {8{EMPTY}};
    logic [1535:0] m; logic [3:0] n; int lat, pulses, drops;
    f[0] = {3'd7, 11'd1532};
    run_frame(f, m, n, lat, pulses, drops);
    checks++; if (m !== ref_map(f)) begin errors++; $display("FAIL top_clip_map: got top %h popcount %0d want top f popcount 4", m[1535:1532], $countones(m)); end
    checks++; if (m[7:0] !== 8'h00) begin errors++; $display("FAIL top_no_wrap: got low bits %h want 00", m[7:0]); end
    checks++; if (n !== 4'd1) begin errors++; $display("FAIL top_count: got %0d want 1", n); end
    f[0] = {3'd0, 11'd1536};
    run_frame(f, m, n, lat, pulses, drops);
    checks++; if (m !== '0) begin errors++; $display("FAIL empty_map: got popcount %0d want 0", $countones(m)); end
    checks++; if (n !== 4'd0) begin errors++; $display("FAIL empty_count: got %0d want 0", n); end
    checks++; if (pulses != 1) begin errors++; $display("FAIL empty_publish: got %0d want 1", pulses); end
  endtask

  task automatic test_back_to_back();
    int pulses = 0, drops = 0, last = -1;
    exp_q.delete();
    n_q.delete();
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          frame_t f = rand_frame();
          @(negedge clk);
          set_words(f);
          clusters_valid = 1'b1;
          exp_q.push_back(ref_map(f));
          n_q.push_back(ref_count(f));
          @(negedge clk);
          clusters_valid = 1'b0;
          set_junk();
          repeat (2) @(negedge clk);
        end
      end
      begin
        for (int c = 0; c < 70; c++) begin
          @(negedge clk);
          if (frame_dropped) drops++;
          if (sbits_valid) begin
            pulses++;
            checks++;
            if (exp_q.size() == 0) begin
              errors++; $display("FAIL b2b_unexpected: got publish at cycle %0d want none", c);
            end else begin
              logic [1535:0] em = exp_q.pop_front();
              logic [3:0] en = n_q.pop_front();
              if (sbits !== em || n_clusters !== en) begin
                errors++;
                $display("FAIL b2b_frame: got popcount %0d n %0d want popcount %0d n %0d", $countones(sbits), n_clusters, $countones(em), en);
              end
            end
            if (last >= 0) begin
              checks++;
              if (c - last != 4) begin errors++; $display("FAIL b2b_interval: got %0d want 4", c - last); end
            end
            last = c;
          end
        end
      end
    join
    checks++; if (pulses != 10) begin errors++; $display("FAIL b2b_pulses: got %0d want 10", pulses); end
    checks++; if (drops != 0) begin errors++; $display("FAIL b2b_dropped: got %0d want 0", drops); end
  endtask

  task automatic test_drop();
    frame_t fa = rand_frame();
    frame_t fb = rand_frame();
    logic [1535:0] got = '0;
    logic [3:0] gn = '0;
    int pulses = 0, drops = 0;
    logic busy_at_b = 1'b0;
    fb[0] = {3'd7, 11'd0};
    @(negedge clk);
    set_words(fa);
    clusters_valid = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) begin clusters_valid = 1'b0; set_junk(); end
      if (k == 2) begin set_words(fb); clusters_valid = 1'b1; busy_at_b = busy; end
      if (k == 3) begin clusters_valid = 1'b0; set_junk(); end
      if (frame_dropped) drops++;
      if (sbits_valid) begin
        pulses++;
        if (pulses == 1) begin got = sbits; gn = n_clusters; end
      end
    end
    checks++; if (busy_at_b !== 1'b1) begin errors++; $display("FAIL drop_busy: got %b want 1", busy_at_b); end
    checks++; if (drops != 1) begin errors++; $display("FAIL drop_pulse: got %0d want 1", drops); end
    checks++; if (pulses != 1) begin errors++; $display("FAIL drop_publishes: got %0d want 1", pulses); end
    checks++; if (got !== ref_map(fa) || gn !== ref_count(fa)) begin errors++; $display("FAIL drop_first_frame: got popcount %0d n %0d want popcount %0d n %0d", $countones(got), gn, $countones(ref_map(fa)), ref_count(fa)); end
  endtask

  task automatic test_loopback();
    for (int it = 0; it < 24; it++) begin
      logic [1535:0] src = '0;
      logic [1535:0] m; logic [3:0] n; int lat, pulses, drops;
      frame_t f;
      int nc;
      int runs = $urandom_range(0, 8);
      for (int r = 0; r < runs; r++) begin
        int pos = $urandom_range(0, 1535);
        int len = $urandom_range(1, 8);
        for (int j = 0; j < len; j++) if (pos + j < 1536) src[pos + j] = 1'b1;
      end
      nc = pack_map(src, f);
      if (nc <= 8) begin
        run_frame(f, m, n, lat, pulses, drops);
        checks++; if (m !== src) begin errors++; $display("FAIL loopback_map[%0d]: got popcount %0d want %0d", it, $countones(m), $countones(src)); end
        checks++; if (n !== 4'(nc)) begin errors++; $display("FAIL loopback_count[%0d]: got %0d want %0d", it, n, nc); end
      end
    end
  endtask

`ifdef CLUSTER_UNPACKER_OVERLAP_CHECK_EN
  task automatic test_overlap();
    frame_t f = {8{EMPTY}};
    logic [1535:0] m; logic [3:0] n; int lat, pulses, drops;
    f[0] = {3'd3, 11'd10};
    f[5] = {3'd0, 11'd12};
    run_frame(f, m, n, lat, pulses, drops);
    checks++; if (obs_ovl !== 1'b1) begin errors++; $display("FAIL overlap_cross_beat: got %b want 1", obs_ovl); end
    f = {8{EMPTY}};
    f[2] = {3'd2, 11'd100};
    f[3] = {3'd0, 11'd101};
    run_frame(f, m, n, lat, pulses, drops);
    checks++; if (obs_ovl !== 1'b1) begin errors++; $display("FAIL overlap_same_beat: got %b want 1", obs_ovl); end
    f = {8{EMPTY}};
    f[0] = {3'd3, 11'd10};
    f[5] = {3'd0, 11'd14};
    run_frame(f, m, n, lat, pulses, drops);
    checks++; if (obs_ovl !== 1'b0) begin errors++; $display("FAIL overlap_disjoint: got %b want 0", obs_ovl); end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    for (int i = 0; i < 8; i++) cl[i] = EMPTY;
    test_reset();
    test_single();
    test_spread();
    test_edges();
    test_back_to_back();
    repeat (8) @(negedge clk);
    test_drop();
    test_reset_abort();
    test_loopback();
`ifdef CLUSTER_UNPACKER_OVERLAP_CHECK_EN
    test_overlap();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
